// File: rtl/lmg_move_unpacker.sv
// Unpacks 8-slot LMG FIFO words into a stream of 18-bit moves with a running index,
// ending the list on an all-invalid word or an empty FIFO.
//
// state     | meaning
// IDLE      | waiting for start, move_count holds last list total
// WAIT_DONE | list started, waiting for the generator to finish
// REQ       | pop one FIFO word, or finish if the FIFO is empty
// WAIT_DATA | read latency in flight, latch word and valid mask
// SCAN      | hand out valid slots lowest-first, one per handshake
// FINISH    | one-cycle list_done pulse
module lmg_move_unpacker #(
  parameter int SLOTS    = 8,
  parameter int MOVE_W   = 18,
  parameter int CNT_W    = 8,
  parameter int FIFO_LAT = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        lmg_done,
  input  logic                        lmg_fifo_empty,
  output logic                        lmg_rden,
  input  logic [SLOTS*(MOVE_W+1)-1:0] lmg_fifo_out,
  output logic                        move_valid,
  input  logic                        move_ready,
  output logic [MOVE_W-1:0]           move_data,
  output logic [CNT_W-1:0]            move_index,
  output logic [CNT_W-1:0]            move_count,
  output logic                        list_done,
  output logic                        overflow,
  output logic                        busy
);

  localparam int SLOT_W = MOVE_W + 1;
  localparam int LAT_W  = (FIFO_LAT > 1) ? $clog2(FIFO_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {IDLE, WAIT_DONE, REQ, WAIT_DATA, SCAN, FINISH} state_t;

  state_t            state, stateNext;
  logic [MOVE_W-1:0] slotData [SLOTS];
  logic [SLOTS-1:0]  mask, fifoMask, selOh;
  logic [MOVE_W-1:0] selData;
  logic [CNT_W-1:0]  moveCount;
  logic              overflowReg;
  logic [LAT_W-1:0]  latCnt;
  logic              accept, latchWord;

  always_comb begin
    fifoMask = '0;
    for (int k = 0; k < SLOTS; k++) fifoMask[k] = ~lmg_fifo_out[k*SLOT_W + MOVE_W];
  end

  // Walk from the top so the lowest set mask bit wins.
  always_comb begin
    selOh   = '0;
    selData = '0;
    for (int k = SLOTS - 1; k >= 0; k--) begin
      if (mask[k]) begin
        selOh    = '0;
        selOh[k] = 1'b1;
        selData  = slotData[k];
      end
    end
  end

  assign accept    = (state == SCAN) && move_ready;
  assign latchWord = (state == WAIT_DATA) && (latCnt == '0);

  always_comb begin
    stateNext = state;
    lmg_rden  = 1'b0;
    case (state)
      IDLE:      if (start) stateNext = WAIT_DONE;
      WAIT_DONE: if (lmg_done) stateNext = REQ;
      REQ: begin
        if (lmg_fifo_empty) begin
          stateNext = FINISH;
        end else begin
          lmg_rden  = 1'b1;
          stateNext = WAIT_DATA;
        end
      end
      WAIT_DATA: if (latchWord) stateNext = (fifoMask == '0) ? FINISH : SCAN;
      SCAN:      if (accept && ((mask & ~selOh) == '0)) stateNext = REQ;
      FINISH:    stateNext = IDLE;
      default:   stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      mask        <= '0;
      moveCount   <= '0;
      overflowReg <= 1'b0;
      latCnt      <= '0;
      for (int k = 0; k < SLOTS; k++) slotData[k] <= '0;
    end else begin
      state <= stateNext;
      if (state == IDLE && start) begin
        moveCount   <= '0;
        overflowReg <= 1'b0;
      end
      if (state == REQ && !lmg_fifo_empty) begin
        latCnt <= LAT_W'(FIFO_LAT - 1);
      end else if (state == WAIT_DATA && latCnt != '0) begin
        latCnt <= latCnt - 1'b1;
      end
      if (latchWord) begin
        mask <= fifoMask;
        for (int k = 0; k < SLOTS; k++) slotData[k] <= lmg_fifo_out[k*SLOT_W +: MOVE_W];
      end else if (accept) begin
        mask <= mask & ~selOh;
      end
      // Count saturates; later moves are still handed out at the max index.
      if (accept) begin
        if (moveCount == CNT_MAX) overflowReg <= 1'b1;
        else                      moveCount   <= moveCount + 1'b1;
      end
    end
  end

  assign move_valid = (state == SCAN);
  assign move_data  = move_valid ? selData : '0;
  assign move_index = move_valid ? moveCount : '0;
  assign move_count = moveCount;
  assign list_done  = (state == FINISH);
  assign overflow   = overflowReg;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_lmg_move_unpacker.sv
// Randomized and directed bench for lmg_move_unpacker; the expected move list is
// derived directly from the FIFO word contents.
module tb_lmg_move_unpacker;
  localparam int WW = 152;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic            lmg_done = 1'b0;
  logic            lmg_fifo_empty = 1'b1;
  logic            lmg_rden;
  logic [WW-1:0]   lmg_fifo_out = '0;
  logic            move_valid;
  logic            move_ready = 1'b0;
  logic [17:0]     move_data;
  logic [7:0]      move_index;
  logic [7:0]      move_count;
  logic            list_done;
  logic            overflow;
  logic            busy;

  always #5 clk = ~clk;

  lmg_move_unpacker dut (
    .clk(clk), .reset(reset), .start(start), .lmg_done(lmg_done),
    .lmg_fifo_empty(lmg_fifo_empty), .lmg_rden(lmg_rden), .lmg_fifo_out(lmg_fifo_out),
    .move_valid(move_valid), .move_ready(move_ready), .move_data(move_data),
    .move_index(move_index), .move_count(move_count), .list_done(list_done),
    .overflow(overflow), .busy(busy)
  );

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [WW-1:0] stimQ[$];
  logic [WW-1:0] fifoQ[$];
  logic [17:0]   gotData[$];
  int            gotIdx[$];
  int            gotCyc[$];
  int            cyc = 0, rdenCnt = 0, doneCnt = 0, readyMode = 0;
  bit            rdPend = 0, prevHold = 0;
  logic [17:0]   prevData;
  logic [7:0]    prevIdx;

  // One clock: drive ready and monitor at negedge, service FIFO reads just after posedge.
  task automatic tick();
    @(negedge clk);
    case (readyMode)
      0:       move_ready = 1'b1;
      1:       move_ready = ~move_ready;
      default: move_ready = ($urandom_range(0, 2) != 0);
    endcase
    if (reset) begin
      if (lmg_rden) begin
        rdenCnt++;
        rdPend = 1;
      end
      if (prevHold) begin
        chk("hold_valid", 64'(move_valid), 64'(1));
        chk("hold_data", 64'(move_data), 64'(prevData));
        chk("hold_index", 64'(move_index), 64'(prevIdx));
      end
      if (move_valid && move_ready) begin
        gotData.push_back(move_data);
        gotIdx.push_back(int'(move_index));
        gotCyc.push_back(cyc);
      end
      prevHold = move_valid && !move_ready;
      prevData = move_data;
      prevIdx  = move_index;
      if (list_done) doneCnt++;
    end else begin
      prevHold = 0;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (rdPend) begin
      rdPend = 0;
      if (fifoQ.size() > 0) lmg_fifo_out = fifoQ.pop_front();
    end
    lmg_fifo_empty = (fifoQ.size() == 0);
  endtask

  function automatic logic [WW-1:0] setSlot(logic [WW-1:0] w, int k, logic [17:0] p);
    logic [WW-1:0] r;
    r = w;
    r[k*19 +: 19] = {1'b0, p};
    return r;
  endfunction

  function automatic logic [WW-1:0] randWord(int pct);
    logic [WW-1:0] w;
    for (int k = 0; k < 8; k++) begin
      w[k*19 +: 19] = {($urandom_range(0, 99) >= pct), 18'($urandom)};
    end
    return w;
  endfunction

  task automatic loadAndStart(input int mode, input bit goDone);
    readyMode = mode;
    lmg_done  = 1'b0;
    fifoQ     = stimQ;
    lmg_fifo_empty = (fifoQ.size() == 0);
    gotData.delete();
    gotIdx.delete();
    gotCyc.delete();
    rdenCnt  = 0;
    doneCnt  = 0;
    prevHold = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    lmg_done = goDone;
  endtask

  task automatic waitDone();
    int n = 0;
    while (doneCnt == 0 && n < 5000) begin
      tick();
      n++;
    end
    if (doneCnt == 0) chk("list_done_timeout", 64'(0), 64'(1));
    tick();
    tick();
    lmg_done = 1'b0;
  endtask

  // Reference: read words in order, collect valid slots lowest-first, stop after an all-invalid word.
  task automatic checkList(input bit backToBack);
    logic [17:0] expQ[$];
    int          expReads = 0;
    int          n, m;
    bit          any;
    foreach (stimQ[w]) begin
      expReads++;
      any = 0;
      for (int k = 0; k < 8; k++) begin
        if (!stimQ[w][k*19 + 18]) begin
          expQ.push_back(stimQ[w][k*19 +: 18]);
          any = 1;
        end
      end
      if (!any) break;
    end
    n = expQ.size();
    chk("n_moves", 64'(gotData.size()), 64'(n));
    m = (gotData.size() < n) ? gotData.size() : n;
    for (int i = 0; i < m; i++) begin
      chk("move_data", 64'(gotData[i]), 64'(expQ[i]));
      chk("move_index", 64'(gotIdx[i]), 64'((i > 255) ? 255 : i));
      if (backToBack && i > 0) chk("back_to_back", 64'(gotCyc[i] - gotCyc[i-1]), 64'(1));
    end
    chk("move_count", 64'(move_count), 64'((n > 255) ? 255 : n));
    chk("overflow", 64'(overflow), 64'(n > 255));
    chk("rden_pulses", 64'(rdenCnt), 64'(expReads));
    chk("done_pulses", 64'(doneCnt), 64'(1));
    chk("busy_after", 64'(busy), 64'(0));
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, "_valid"}, 64'(move_valid), 64'(0));
    chk({tag, "_data"}, 64'(move_data), 64'(0));
    chk({tag, "_index"}, 64'(move_index), 64'(0));
    chk({tag, "_count"}, 64'(move_count), 64'(0));
    chk({tag, "_done"}, 64'(list_done), 64'(0));
    chk({tag, "_ovf"}, 64'(overflow), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_rden"}, 64'(lmg_rden), 64'(0));
  endtask

  logic [WW-1:0] wordA;
  logic [WW-1:0] allInv;

  initial begin
    allInv = '1;
    wordA  = setSlot(setSlot(setSlot(allInv, 0, 18'h00123), 3, 18'h00456), 7, 18'h3FFFF);

    reset = 1'b0;
    repeat (3) tick();
    checkAllZero("reset");
    reset = 1'b1;
    tick();

    // Sparse word then end marker, consumer always ready.
    stimQ = {wordA, allInv};
    loadAndStart(0, 1'b1);
    waitDone();
    checkList(1'b1);

    // Same list with alternating ready.
    loadAndStart(1, 1'b1);
    waitDone();
    checkList(1'b0);

    // Empty FIFO at the first request.
    stimQ.delete();
    loadAndStart(0, 1'b1);
    waitDone();
    checkList(1'b0);

    // Three full words ended by an empty FIFO.
    stimQ.delete();
    repeat (3) stimQ.push_back(randWord(100));
    loadAndStart(2, 1'b1);
    waitDone();
    checkList(1'b0);

    // 272 moves saturate the 8-bit count.
    stimQ.delete();
    repeat (34) stimQ.push_back(randWord(100));
    loadAndStart(0, 1'b1);
    waitDone();
    checkList(1'b0);

    // Start while busy is ignored; no reads without lmg_done.
    stimQ = {wordA, allInv};
    loadAndStart(0, 1'b0);
    repeat (8) tick();
    chk("wait_done_busy", 64'(busy), 64'(1));
    chk("wait_done_rden", 64'(rdenCnt), 64'(0));
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("restart_busy", 64'(busy), 64'(1));
    chk("restart_rden", 64'(rdenCnt), 64'(0));
    chk("restart_done", 64'(doneCnt), 64'(0));
    lmg_done = 1'b1;
    waitDone();
    checkList(1'b1);

    // Reset while the third move is presented.
    begin
      bit found = 0;
      loadAndStart(0, 1'b1);
      for (int n = 0; n < 50 && !found; n++) begin
        tick();
        if (move_valid && move_index == 8'd2) found = 1;
      end
      chk("reach_move2", 64'(found), 64'(1));
      reset = 1'b0;
      #1;
      checkAllZero("midreset");
      doneCnt = 0;
      repeat (3) tick();
      chk("midreset_idle", 64'(busy), 64'(0));
      reset = 1'b1;
      tick();
      chk("midreset_nodone", 64'(doneCnt), 64'(0));
      loadAndStart(0, 1'b1);
      waitDone();
      checkList(1'b1);
    end

    // Random lists: mixed densities, optional end marker with unread trailing words.
    for (int t = 0; t < 25; t++) begin
      int nw, pct;
      stimQ.delete();
      nw = $urandom_range(0, 4);
      for (int w = 0; w < nw; w++) begin
        pct = $urandom_range(0, 2);
        stimQ.push_back(randWord((pct == 0) ? 25 : (pct == 1) ? 60 : 100));
      end
      if ($urandom_range(0, 1) == 1) begin
        stimQ.push_back(randWord(0));
        if ($urandom_range(0, 1) == 1) stimQ.push_back(randWord(100));
      end
      loadAndStart(2, 1'b1);
      waitDone();
      checkList(1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
